// File: rtl/seatbelt_warn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seatbelt_warn_ctrl
// Description : Multi-seat seatbelt reminder. Escalates steady LED -> blinking
//               LED with pulsed chime -> continuous alarm for unbuckled seats.
// Revision    : 1.0 - initial release
// ============================================================================
module seatbelt_warn_ctrl #(
    parameter int NUM_SEATS    = 4,
    parameter int GRACE_CYCLES = 1024,
    parameter int BLINK_HALF   = 256,
    parameter int WARN_CYCLES  = 8192,
    parameter int EVT_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 key,
    input  logic [NUM_SEATS-1:0] occupied,
    input  logic [NUM_SEATS-1:0] buckled,
    output logic [NUM_SEATS-1:0] led,
    output logic                 chime,
    output logic                 alarm,
    output logic [EVT_W-1:0]     warn_events
);

    localparam int TMAX = (GRACE_CYCLES > WARN_CYCLES) ? GRACE_CYCLES : WARN_CYCLES;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int PW   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [TW-1:0] c_grace_last = TW'(GRACE_CYCLES - 1);
    localparam logic [TW-1:0] c_warn_last  = TW'(WARN_CYCLES - 1);
    localparam logic [PW-1:0] c_phase_last = PW'(BLINK_HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_GRACE = 3'd2,
        S_WARN  = 3'd3,
        S_ALARM = 3'd4
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [TW-1:0]         r_timer, w_timer_nxt;
    logic [PW-1:0]         r_phase, w_phase_nxt;
    logic                  r_blink, w_blink_nxt;
    logic                  w_evt_inc;
    logic [EVT_W-1:0]      r_evt;
    logic [NUM_SEATS-1:0]  w_unf;
    logic                  w_any_unf;
    logic [NUM_SEATS-1:0]  r_led, w_led_nxt;
    logic                  r_chime, w_chime_nxt;
    logic                  r_alarm, w_alarm_nxt;

    // Driver seat counts as occupied regardless of its sensor.
    always_comb begin
        w_unf    = occupied & ~buckled;
        w_unf[0] = ~buckled[0];
    end

    assign w_any_unf = |w_unf;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_phase_nxt = r_phase;
        w_blink_nxt = r_blink;
        w_evt_inc   = 1'b0;
        if (!key) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: w_state_nxt = S_ARMED;
                S_ARMED: begin
                    if (w_any_unf) begin
                        w_state_nxt = S_GRACE;
                        w_timer_nxt = '0;
                    end
                end
                S_GRACE: begin
                    if (!w_any_unf) begin
                        w_state_nxt = S_ARMED;
                    end else if (r_timer == c_grace_last) begin
                        w_state_nxt = S_WARN;
                        w_timer_nxt = '0;
                        w_phase_nxt = '0;
                        w_blink_nxt = 1'b1;
                        w_evt_inc   = 1'b1;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
                S_WARN: begin
                    if (!w_any_unf) begin
                        w_state_nxt = S_ARMED;
                    end else if (r_timer == c_warn_last) begin
                        w_state_nxt = S_ALARM;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                        if (r_phase == c_phase_last) begin
                            w_phase_nxt = '0;
                            w_blink_nxt = ~r_blink;
                        end else begin
                            w_phase_nxt = r_phase + 1'b1;
                        end
                    end
                end
                S_ALARM: begin
                    if (!w_any_unf) w_state_nxt = S_ARMED;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Outputs follow the next state so they line up with the registered state.
    always_comb begin
        w_led_nxt   = '0;
        w_chime_nxt = 1'b0;
        w_alarm_nxt = 1'b0;
        case (w_state_nxt)
            S_GRACE: w_led_nxt = w_unf;
            S_WARN: begin
                w_led_nxt   = w_unf & {NUM_SEATS{w_blink_nxt}};
                w_chime_nxt = w_blink_nxt;
            end
            S_ALARM: begin
                w_led_nxt   = w_unf;
                w_chime_nxt = 1'b1;
                w_alarm_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_timer <= '0;
            r_phase <= '0;
            r_blink <= 1'b0;
            r_evt   <= '0;
            r_led   <= '0;
            r_chime <= 1'b0;
            r_alarm <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_phase <= w_phase_nxt;
            r_blink <= w_blink_nxt;
            if (w_evt_inc && (r_evt != {EVT_W{1'b1}}))
                r_evt <= r_evt + 1'b1;
            r_led   <= w_led_nxt;
            r_chime <= w_chime_nxt;
            r_alarm <= w_alarm_nxt;
        end
    end

    assign led         = r_led;
    assign chime       = r_chime;
    assign alarm       = r_alarm;
    assign warn_events = r_evt;

endmodule
`default_nettype wire

// File: tb/tb_seatbelt_warn_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seatbelt_warn_ctrl
// Description : Vector-table and scoreboard bench for seatbelt_warn_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seatbelt_warn_ctrl;

    localparam int G  = 8;
    localparam int BH = 2;
    localparam int W  = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       key;
    logic [3:0] occupied;
    logic [3:0] buckled;
    logic [3:0] led;
    logic       chime;
    logic       alarm;
    logic [1:0] warn_events;

    always #5 clk = ~clk;

    seatbelt_warn_ctrl #(
        .NUM_SEATS   (4),
        .GRACE_CYCLES(G),
        .BLINK_HALF  (BH),
        .WARN_CYCLES (W),
        .EVT_W       (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .occupied   (occupied),
        .buckled    (buckled),
        .led        (led),
        .chime      (chime),
        .alarm      (alarm),
        .warn_events(warn_events)
    );

    typedef struct {
        logic       key;
        logic [3:0] occ;
        logic [3:0] bkl;
        logic [3:0] led;
        logic       chime;
        logic       alarm;
        logic [1:0] evt;
    } vec_t;

    typedef struct {
        logic [3:0] led;
        logic       chime;
        logic       alarm;
        logic [1:0] evt;
    } exp_t;

    vec_t  tbl[$];
    exp_t  sb[$];
    int    errors = 0;
    int    checks = 0;
    string scen   = "reset";

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s/%s at %0t: got %0h expected %0h", scen, name, $time, act, exp);
        end
    endtask

    task automatic apply(vec_t v);
        exp_t e;
        key      = v.key;
        occupied = v.occ;
        buckled  = v.bkl;
        sb.push_back('{v.led, v.chime, v.alarm, v.evt});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("led",   {4'b0, led},         {4'b0, e.led});
        chk("chime", {7'b0, chime},       {7'b0, e.chime});
        chk("alarm", {7'b0, alarm},       {7'b0, e.alarm});
        chk("evt",   {6'b0, warn_events}, {6'b0, e.evt});
    endtask

    task automatic cyc(logic k, logic [3:0] o, logic [3:0] b, logic [3:0] l,
                       logic c, logic a, logic [1:0] ev);
        vec_t v;
        v = '{k, o, b, l, c, a, ev};
        apply(v);
    endtask

    task automatic run_tbl();
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Expected outputs n cycles after key-on from IDLE with seats 0..2 unbuckled:
    // n=0 ARMED, 1..G GRACE, next W cycles WARN (blink starts high), then ALARM.
    function automatic vec_t esc(int n, int bk_n, logic [3:0] bk_val,
                                 logic [3:0] pre, logic [3:0] post, logic [1:0] evt0);
        vec_t       v;
        logic [3:0] pat;
        logic [1:0] evt1;
        logic       b;
        evt1    = (evt0 == 2'd3) ? 2'd3 : evt0 + 2'd1;
        v.key   = 1'b1;
        v.occ   = 4'b0110;
        v.bkl   = (n >= bk_n) ? bk_val : 4'b0000;
        pat     = (n >= bk_n) ? post : pre;
        v.led   = 4'b0000;
        v.chime = 1'b0;
        v.alarm = 1'b0;
        v.evt   = evt0;
        if (n >= 1 && n <= G) begin
            v.led = pat;
        end else if (n > G && n <= G + W) begin
            b       = (((n - G - 1) / BH) % 2) == 0;
            v.led   = b ? pat : 4'b0000;
            v.chime = b;
            v.evt   = evt1;
        end else if (n > G + W) begin
            v.led   = pat;
            v.chime = 1'b1;
            v.alarm = 1'b1;
            v.evt   = evt1;
        end
        return v;
    endfunction

    initial begin
        rst      = 1'b1;
        key      = 1'b0;
        occupied = 4'b0000;
        buckled  = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_led",   {4'b0, led},         8'h00);
        chk("rst_chime", {7'b0, chime},       8'h00);
        chk("rst_alarm", {7'b0, alarm},       8'h00);
        chk("rst_evt",   {6'b0, warn_events}, 8'h00);
        rst = 1'b0;

        scen = "key_off";
        repeat (6) cyc(1'b0, 4'b1111, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);

        // Driver unbuckled, buckles during grace, then unbuckles for a fresh grace.
        scen = "grace";
        cyc(1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0);
        for (int n = 1; n <= 4; n++)
            cyc(1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'd0);
        repeat (6) cyc(1'b1, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0);
        scen = "reentry";
        repeat (G) cyc(1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, 2'd0);
        cyc(1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd1);
        cyc(1'b1, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0, 2'd1);

        // Reset mid-WARN must clear outputs without any clock edge.
        scen = "async_rst";
        #2;
        rst = 1'b1;
        #1;
        chk("led",   {4'b0, led},         8'h00);
        chk("chime", {7'b0, chime},       8'h00);
        chk("evt",   {6'b0, warn_events}, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;

        scen = "escalate";
        for (int n = 0; n <= 28; n++) tbl.push_back(esc(n, 999, 4'b0000, 4'b0111, 4'b0111, 2'd0));
        run_tbl();

        scen = "key_off_alarm";
        cyc(1'b0, 4'b0110, 4'b1111, 4'b0000, 1'b0, 1'b0, 2'd1);
        scen = "key_on_again";
        for (int n = 0; n <= 10; n++) tbl.push_back(esc(n, 999, 4'b0000, 4'b0111, 4'b0111, 2'd1));
        run_tbl();

        scen = "partial_buckle";
        pulse_reset();
        for (int n = 0; n <= 28; n++) tbl.push_back(esc(n, 14, 4'b0010, 4'b0111, 4'b0101, 2'd0));
        run_tbl();

        scen = "saturate";
        pulse_reset();
        for (int k = 0; k < 5; k++) begin
            logic [1:0] e0;
            logic [1:0] e1;
            e0 = (k > 3) ? 2'd3 : 2'(k);
            e1 = (k + 1 > 3) ? 2'd3 : 2'(k + 1);
            for (int n = 0; n <= G + 1; n++) tbl.push_back(esc(n, 999, 4'b0000, 4'b0111, 4'b0111, e0));
            run_tbl();
            cyc(1'b0, 4'b0110, 4'b0000, 4'b0000, 1'b0, 1'b0, e1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seatbelt_warn_ctrl.md
Name: seatbelt_warn_ctrl

Overview:
Multi-seat seatbelt reminder controller for the car body block. It monitors N seats for "occupied and not buckled" while the ignition key is on. After a grace period it escalates from a steady per-seat indicator to a blinking indicator with a pulsed chime, and then to a continuous alarm. It feeds the dashboard LED bank and the chime driver, and replaces the single-seat, non-timed indicator.

Parameters:
NUM_SEATS, 4, number of seats monitored; seat 0 is the driver seat and is always treated as occupied (>=1)
GRACE_CYCLES, 1024, clk cycles of steady indication before blinking starts (>=1)
BLINK_HALF, 256, clk cycles per blink half-period in WARN (>=1)
WARN_CYCLES, 8192, clk cycles spent in WARN before ALARM (>=1)
EVT_W, 8, width of the saturating warning-event counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
key  in  1  ignition key on
occupied  in  NUM_SEATS  seat occupancy sensors; bit 0 is ignored
buckled  in  NUM_SEATS  buckle switches
led  out  NUM_SEATS  per-seat warning indicator, registered
chime  out  1  chime drive, registered
alarm  out  1  high while in ALARM state, registered
warn_events  out  EVT_W  count of GRACE->WARN transitions since reset; saturates at all-ones

Behaviour:
- Reset: asynchronous, active-high. State = IDLE; all counters = 0; led = 0, chime = 0, alarm = 0, warn_events = 0. Reset asserted mid-operation forces this state immediately, with no completion of any timer.
- Inputs are synchronous to clk; there is no internal synchroniser.
- unf[i] = (occupied[i] | (i==0)) & ~buckled[i]. any_unf = OR of unf.
- States are IDLE, ARMED, GRACE, WARN, ALARM. key==0 in any state sends the FSM to IDLE on the next edge, and this takes priority over every other transition.
- IDLE: key==1 -> ARMED.
- ARMED: any_unf -> GRACE, with timer cleared to 0.
- GRACE: timer increments each cycle. !any_unf -> ARMED (has priority over timeout). timer==GRACE_CYCLES-1 -> WARN, timer cleared, blink phase reset, warn_events incremented unless already saturated.
- WARN: timer increments. !any_unf -> ARMED. timer==WARN_CYCLES-1 -> ALARM.
- ALARM: stays in ALARM until !any_unf (-> ARMED) or key==0 (-> IDLE).
- Seats that buckle or unbuckle while in GRACE/WARN/ALARM do not restart timers as long as any_unf stays 1. Their led bits update on the next edge.
- Outputs are registered and computed from the next state and the current inputs, so there is 1 clk of latency from input change to output:
  - IDLE, ARMED: led = 0, chime = 0, alarm = 0.
  - GRACE: led = unf, chime = 0.
  - WARN: led = unf & {NUM_SEATS{blink}}, chime = blink.
  - ALARM: led = unf, chime = 1, alarm = 1.
- Blink: blink = 1 on the first WARN cycle. A phase counter runs 0..BLINK_HALF-1, and blink toggles when it wraps. The period is 2*BLINK_HALF cycles.
- Counter widths: timer is sized for max(GRACE_CYCLES, WARN_CYCLES); phase counter is sized for BLINK_HALF. Neither counter may wrap within a state.
- Re-entry: leaving WARN or ALARM to ARMED and then seeing a new unbuckle restarts the full grace period.

Test Plan:
Params for all tests: NUM_SEATS=4, GRACE_CYCLES=8, BLINK_HALF=2, WARN_CYCLES=16, EVT_W=2.

1. Reset/idle: rst pulsed mid-WARN -> outputs 0 immediately (asynchronous, no clk edge needed). key=0 with all seats unbuckled -> led=0, chime=0 indefinitely.
2. Grace path: key=1, occupied=0, buckled=0000 -> led=0001 one cycle after entering GRACE, steady for 8 cycles. buckled[0] set at cycle 5 -> led=0000 next edge, state ARMED, chime never high.
3. Blink/escalate: key=1, occupied=0110, buckled=0000 -> led=0111 steady for 8 cycles. Then 16 cycles of led toggling 0111/0000 every 2 cycles with chime in phase (starting high). Then led=0111, chime=1, alarm=1 held. warn_events=1.
4. Partial buckle in WARN: from scenario 3, buckle seat 1 mid-WARN -> led pattern becomes 0101 blinking, no timer restart, ALARM at the original time.
5. Key off priority: key dropped in ALARM on the same cycle seats buckle -> IDLE, all outputs 0 next edge. key=1 again with seats unbuckled -> full 8-cycle grace before blinking.
6. Saturation: 5 GRACE->WARN entries -> warn_events reads 1, 2, 3, 3, 3.
